// File: rtl/fifo_push_arbiter_if.sv
// fifo_push_arbiter_if: handshake bundle between two requesters, the arbiter and a FIFO write port
interface fifo_push_arbiter_if #(parameter int DATA_WIDTH = 2);
  logic req0_valid, req0_ready, req1_valid, req1_ready, fifo_full, fifo_push;
  logic [DATA_WIDTH-1:0] req0_data, req1_data, fifo_din;
  logic [1:0] grant;
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    output req0_ready, req1_ready, fifo_push, fifo_din, grant
  );
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full,
    input  req0_ready, req1_ready, fifo_push, fifo_din, grant
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: two-requester burst-fair arbiter feeding one FIFO push port
module fifo_push_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int BURST      = 4
) (
  input logic clk,
  input logic reset,
  fifo_push_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST);
  typedef enum logic [1:0] {IDLE = 2'b00, GNT0 = 2'b01, GNT1 = 2'b10} state_t;
  state_t r_state, w_next, w_other;
  logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic r_last, w_last_next;
  logic w_rdy0, w_rdy1, w_xfer, w_cur_v, w_oth_v;
  logic [DATA_WIDTH-1:0] w_din;
  always_comb begin
    w_rdy0 = (r_state == GNT0) & ~bus.fifo_full & reset;
    w_rdy1 = (r_state == GNT1) & ~bus.fifo_full & reset;
    w_xfer = (w_rdy0 & bus.req0_valid) | (w_rdy1 & bus.req1_valid);
    w_cur_v = (r_state == GNT0) ? bus.req0_valid : bus.req1_valid;
    w_oth_v = (r_state == GNT0) ? bus.req1_valid : bus.req0_valid;
    w_other = (r_state == GNT0) ? GNT1 : GNT0;
    w_cnt_inc = r_cnt + 1'b1;
    w_din = (r_state == GNT0) ? bus.req0_data : (r_state == GNT1) ? bus.req1_data : '0;
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (bus.req0_valid & (~bus.req1_valid | r_last)) ? GNT0 : bus.req1_valid ? GNT1 : IDLE;
    else if (!w_cur_v)
      w_next = w_oth_v ? w_other : IDLE;
    else if (w_xfer & (w_cnt_inc == LAST_BEAT) & w_oth_v)
      w_next = w_other;
    // a finished burst with nobody waiting starts a fresh burst in place
    w_cnt_next = (w_next != r_state) ? '0 : w_xfer ? ((w_cnt_inc == LAST_BEAT) ? '0 : w_cnt_inc) : r_cnt;
    w_last_next = (w_next == GNT0) ? 1'b0 : (w_next == GNT1) ? 1'b1 : r_last;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_last  <= w_last_next;
    end
  end
  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.fifo_push  = w_xfer;
  assign bus.fifo_din   = w_din;
  assign bus.grant      = r_state;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenarios plus randomized run against a grant/tenure reference model
module tb_fifo_push_arbiter;
  localparam int DW = 8;
  localparam int BURST = 4;
  logic clk, reset;
  int checks = 0, errors = 0;
  fifo_push_arbiter_if #(.DATA_WIDTH(DW)) bus();
  fifo_push_arbiter #(.DATA_WIDTH(DW), .BURST(BURST)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.fifo_full = 0;
    bus.req0_data = '0; bus.req1_data = '0;
  endtask
  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step();
    reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    bus.req0_valid = 1; bus.req1_valid = 1; bus.req0_data = 8'hA5; bus.req1_data = 8'h5A;
    step();
    @(negedge clk);
    checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", bus.grant); end
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %b want 0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %b want 0", bus.req1_ready); end
    checks++; if (bus.fifo_push !== 1'b0) begin errors++; $display("FAIL reset_push got %b want 0", bus.fifo_push); end
    checks++; if (bus.fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din got %0h want 0", bus.fifo_din); end
    reset = 1;
    idle_inputs();
  endtask

  task automatic test_single();
    logic [7:0] nxt;
    logic [1:0] eg;
    nxt = 8'h10;
    do_reset();
    bus.req0_valid = 1;
    for (int c = 1; c <= 10; c++) begin
      bus.req0_data = nxt;
      @(negedge clk);
      eg = (c == 1) ? 2'b00 : 2'b01;
      checks++; if (bus.grant !== eg) begin errors++; $display("FAIL single_grant c%0d got %b want %b", c, bus.grant, eg); end
      checks++; if (bus.fifo_push !== (c > 1)) begin errors++; $display("FAIL single_push c%0d got %b want %b", c, bus.fifo_push, c > 1); end
      checks++; if (bus.fifo_din !== ((c > 1) ? nxt : 8'h00)) begin errors++; $display("FAIL single_din c%0d got %0h want %0h", c, bus.fifo_din, (c > 1) ? nxt : 8'h00); end
      if (c > 1) nxt++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_both();
    logic [6:0] s0, s1;
    logic [1:0] eg;
    logic [7:0] ed;
    int own;
    s0 = 0; s1 = 0;
    do_reset();
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int c = 1; c <= 13; c++) begin
      bus.req0_data = {1'b0, s0};
      bus.req1_data = {1'b1, s1};
      @(negedge clk);
      own = (c == 1) ? 0 : ((((c - 2) / BURST) % 2) == 0) ? 1 : 2;
      eg = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
      ed = (own == 1) ? {1'b0, s0} : (own == 2) ? {1'b1, s1} : 8'h00;
      checks++; if (bus.grant !== eg) begin errors++; $display("FAIL both_grant c%0d got %b want %b", c, bus.grant, eg); end
      checks++; if (bus.fifo_push !== (c > 1)) begin errors++; $display("FAIL both_push c%0d got %b want %b", c, bus.fifo_push, c > 1); end
      checks++; if (bus.fifo_din !== ed) begin errors++; $display("FAIL both_din c%0d got %0h want %0h", c, bus.fifo_din, ed); end
      if (own == 1) s0++;
      if (own == 2) s1++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [7:0] n, ed;
    logic [1:0] eg;
    logic ep;
    n = 8'h20;
    do_reset();
    bus.req0_valid = 1;
    for (int c = 1; c <= 11; c++) begin
      bus.req1_valid = (c >= 4);
      bus.fifo_full = (c >= 4 && c <= 8);
      bus.req0_data = n;
      bus.req1_data = 8'hC0;
      @(negedge clk);
      eg = (c == 1) ? 2'b00 : (c <= 10) ? 2'b01 : 2'b10;
      ep = (c == 2 || c == 3 || c >= 9);
      ed = (c == 1) ? 8'h00 : (c <= 10) ? n : 8'hC0;
      checks++; if (bus.grant !== eg) begin errors++; $display("FAIL stall_grant c%0d got %b want %b", c, bus.grant, eg); end
      checks++; if (bus.fifo_push !== ep) begin errors++; $display("FAIL stall_push c%0d got %b want %b", c, bus.fifo_push, ep); end
      checks++; if (bus.fifo_din !== ed) begin errors++; $display("FAIL stall_din c%0d got %0h want %0h", c, bus.fifo_din, ed); end
      if (ep && c <= 10) n++;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_drop();
    logic [1:0] eg;
    logic ep;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      bus.req0_data = 8'h33; bus.req1_data = 8'h44;
      for (int c = 1; c <= 4; c++) begin
        bus.req1_valid = (c <= 2);
        bus.req0_valid = (p == 0) && (c >= 3);
        @(negedge clk);
        eg = (c == 1) ? 2'b00 : (c <= 3) ? 2'b10 : (p == 0) ? 2'b01 : 2'b00;
        ep = (c == 2) || (c == 4 && p == 0);
        checks++; if (bus.grant !== eg) begin errors++; $display("FAIL drop%0d_grant c%0d got %b want %b", p, c, bus.grant, eg); end
        checks++; if (bus.fifo_push !== ep) begin errors++; $display("FAIL drop%0d_push c%0d got %b want %b", p, c, bus.fifo_push, ep); end
        step();
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [1:0] eg;
    do_reset();
    bus.req1_valid = 1; bus.req0_data = 8'h66; bus.req1_data = 8'h55;
    for (int c = 1; c <= 5; c++) begin
      reset = (c != 3);
      bus.req0_valid = (c >= 3);
      @(negedge clk);
      eg = (c == 1 || c == 4) ? 2'b00 : (c == 5) ? 2'b01 : 2'b10;
      checks++; if (bus.grant !== eg) begin errors++; $display("FAIL rmid_grant c%0d got %b want %b", c, bus.grant, eg); end
      checks++; if (bus.fifo_push !== (c == 2 || c == 5)) begin errors++; $display("FAIL rmid_push c%0d got %b want %b", c, bus.fifo_push, c == 2 || c == 5); end
      checks++; if (bus.req0_ready !== (c == 5)) begin errors++; $display("FAIL rmid_ready0 c%0d got %b want %b", c, bus.req0_ready, c == 5); end
      checks++; if (bus.req1_ready !== (c == 2)) begin errors++; $display("FAIL rmid_ready1 c%0d got %b want %b", c, bus.req1_ready, c == 2); end
      step();
    end
    reset = 1;
    idle_inputs();
  endtask

  task automatic test_random();
    int owner, beats, last_owner, run0, run1;
    logic [6:0] s0, s1, e0, e1;
    logic v0, v1, full, rst, er0, er1, ep, mine, other;
    logic [1:0] eg;
    logic [7:0] ed;
    do_reset();
    owner = 0; beats = 0; last_owner = 1; run0 = 0; run1 = 0;
    s0 = 0; s1 = 0; e0 = 0; e1 = 0;
    for (int c = 0; c < 10000; c++) begin
      v0 = ($urandom_range(9, 0) < 7);
      v1 = ($urandom_range(9, 0) < 7);
      full = ($urandom_range(9, 0) < 2);
      rst = ($urandom_range(199, 0) != 0);
      bus.req0_valid = v0; bus.req1_valid = v1; bus.fifo_full = full; reset = rst;
      bus.req0_data = {1'b0, s0};
      bus.req1_data = {1'b1, s1};
      @(negedge clk);
      er0 = (owner == 1) && !full && rst;
      er1 = (owner == 2) && !full && rst;
      ep = (er0 && v0) || (er1 && v1);
      eg = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      ed = (owner == 1) ? {1'b0, s0} : (owner == 2) ? {1'b1, s1} : 8'h00;
      checks++; if (bus.grant !== eg) begin errors++; $display("FAIL rnd_grant c%0d got %b want %b", c, bus.grant, eg); end
      checks++; if (bus.req0_ready !== er0) begin errors++; $display("FAIL rnd_ready0 c%0d got %b want %b", c, bus.req0_ready, er0); end
      checks++; if (bus.req1_ready !== er1) begin errors++; $display("FAIL rnd_ready1 c%0d got %b want %b", c, bus.req1_ready, er1); end
      checks++; if (bus.fifo_push !== ep) begin errors++; $display("FAIL rnd_push c%0d got %b want %b", c, bus.fifo_push, ep); end
      checks++; if (bus.fifo_din !== ed) begin errors++; $display("FAIL rnd_din c%0d got %0h want %0h", c, bus.fifo_din, ed); end
      checks++; if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin errors++; $display("FAIL rnd_onehot_ready c%0d got %b%b want at most one", c, bus.req1_ready, bus.req0_ready); end
      if (bus.fifo_push === 1'b1) begin
        if (bus.fifo_din[7] == 1'b0) begin
          checks++; if (bus.fifo_din[6:0] !== e0) begin errors++; $display("FAIL rnd_order0 c%0d got %0h want %0h", c, bus.fifo_din[6:0], e0); end
          e0++;
        end else begin
          checks++; if (bus.fifo_din[6:0] !== e1) begin errors++; $display("FAIL rnd_order1 c%0d got %0h want %0h", c, bus.fifo_din[6:0], e1); end
          e1++;
        end
      end
      if (!v0 || !v1 || !rst) begin
        run0 = 0; run1 = 0;
      end else if (bus.fifo_push === 1'b1) begin
        if (bus.fifo_din[7] == 1'b0) begin run0++; run1 = 0; end
        else begin run1++; run0 = 0; end
        checks++; if (run0 > BURST || run1 > BURST) begin errors++; $display("FAIL rnd_starve c%0d got run %0d/%0d want <= %0d", c, run0, run1, BURST); end
      end
      if (bus.req0_valid && bus.req0_ready) s0++;
      if (bus.req1_valid && bus.req1_ready) s1++;
      if (!rst) begin
        owner = 0; beats = 0; last_owner = 1;
      end else if (owner == 0) begin
        if (v0 && (!v1 || last_owner == 1)) begin owner = 1; beats = 0; last_owner = 0; end
        else if (v1) begin owner = 2; beats = 0; last_owner = 1; end
      end else begin
        mine = (owner == 1) ? v0 : v1;
        other = (owner == 1) ? v1 : v0;
        if (!mine) begin
          if (other) begin owner = 3 - owner; beats = 0; last_owner = owner - 1; end
          else owner = 0;
        end else if (!full) begin
          beats++;
          if (beats == BURST) begin
            beats = 0;
            if (other) begin owner = 3 - owner; last_owner = owner - 1; end
          end
        end
      end
      step();
    end
    reset = 1;
    idle_inputs();
    checks++; if (e0 !== s0) begin errors++; $display("FAIL rnd_count0 got %0d want %0d", e0, s0); end
    checks++; if (e1 !== s1) begin errors++; $display("FAIL rnd_count1 got %0d want %0d", e1, s1); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_both();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 2: width of each requester's data and of the FIFO write data.
REQ-002 Parameter BURST, default 4: maximum beats one requester SHALL push per grant while the other requester is waiting; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req0_valid  input  1  requester 0 has a beat to push.
REQ-006 req0_data  input  DATA_WIDTH  requester 0 beat data.
REQ-007 req0_ready  output  1  requester 0 beat accepted this cycle.
REQ-008 req1_valid, req1_data, req1_ready  same directions, widths and meanings as REQ-005 to REQ-007, for requester 1.
REQ-009 fifo_full  input  1  downstream FIFO cannot accept a push this cycle.
REQ-010 fifo_push  output  1  write strobe to the FIFO.
REQ-011 fifo_din  output  DATA_WIDTH  write data to the FIFO.
REQ-012 grant  output  2  one-hot registered grant: bit0 = requester 0, bit1 = requester 1, 00 = idle.

Function
REQ-013 FSM states: IDLE, GNT0, GNT1; grant SHALL equal 00, 01, 10 respectively.
REQ-014 Registered state: last_served (1 bit) and beat counter cnt (width ceil(log2(BURST+1))).
REQ-015 Transfer: reqN_ready = (state==GNTN) & ~fifo_full & reset, combinational; a beat transfers when reqN_valid & reqN_ready.
REQ-016 fifo_push SHALL equal the OR of both transfer conditions; fifo_din SHALL equal the granted requester's data in GNT0/GNT1 and all-zeros in IDLE.
REQ-017 At most one requester SHALL be ready in any cycle; a non-granted requester's ready SHALL be 0.
REQ-018 IDLE: ready outputs are 0. If exactly one valid, go to that GNT. If both valid, go to GNT of the requester not equal to last_served. If none valid, stay in IDLE.
REQ-019 Entering GNTN: cnt <= 0 and last_served <= N.
REQ-020 GNTN, reqN_valid=1, fifo_full=1: stall. State and cnt are held; a stall SHALL NOT cause a grant switch.
REQ-021 GNTN on a transfer: cnt increments. If cnt+1 == BURST and the other requester's valid is 1, switch to the other GNT on the next edge. If cnt+1 == BURST and the other is not valid, remain in GNTN with cnt <= 0.
REQ-022 GNTN, reqN_valid=0: if the other requester is valid, switch directly to its GNT with no IDLE bubble; otherwise go to IDLE.
REQ-023 A switch takes effect at the next edge. The newly granted requester MAY transfer in its first granted cycle.
REQ-024 Throughput: one beat per cycle while the granted requester is valid and fifo_full=0, including across grant switches. The only bubble is the IDLE-to-GNT cycle.
REQ-025 Starvation bound: with both requesters continuously valid and fifo_full=0, neither requester SHALL wait more than BURST consecutive transfers.
REQ-026 Data is never modified, reordered within a requester, duplicated, or dropped.

Reset
REQ-027 While reset=0 at a rising edge: state <= IDLE, cnt <= 0, last_served <= 1, so requester 0 wins the first tie.
REQ-028 While reset=0, req0_ready, req1_ready and fifo_push SHALL be 0 combinationally, regardless of state. This holds for a reset asserted mid-burst.
REQ-029 Outputs after reset: grant=00, fifo_push=0, fifo_din=0, both ready=0.

Verification
REQ-030 Reset, then req0_valid=1 only, fifo_full=0, 10 cycles -> grant=01 from cycle 2. fifo_push=1 on cycles 2..10. req0 data appears in order. No switch occurs at the BURST boundary.
REQ-031 Both valid from reset, BURST=4, fifo_full=0 -> grant 01 for 4 transfers, then 10 for 4, then 01 again. fifo_push is continuous after the first IDLE cycle.
REQ-032 In GNT0 with cnt=2, fifo_full=1 for 5 cycles while req1 is valid -> grant stays 01, cnt stays 2, no push. After fifo_full falls, 2 more req0 beats transfer, then grant switches to 10.
REQ-033 In GNT1, req1_valid drops while req0_valid=1 -> grant=01 on the next cycle with no idle cycle. If req0_valid=0 instead, grant becomes 00.
REQ-034 reset pulled low for 1 cycle mid-burst in GNT1 -> ready and push are 0 in that cycle. The next cycle has grant=00, and with both valid requester 0 is then granted.
REQ-035 Random valid/full/data for 10k cycles against a scoreboard -> per-requester order is preserved, no drops or duplicates, and REQ-017 and REQ-025 always hold.
